coef_loader: RTL

Coefficient loader for the ANN: it answers the ANN's `request_coef` by fetching one block of WORDS coefficient words from external coefficient memory and writing them word by word into the ANN coefficient buffer. When the whole block has been written, it signals completion with a one-cycle `image_weights_loaded` pulse. It sits between the board-level coefficient memory and the ANN core, and is the supplying end of the ANN request/loaded handshake.

---
 rtl/coef_loader.sv | 94 +++++++++
 1 files changed

// File: rtl/coef_loader.sv
// Fetches one WORDS-long coefficient block from memory and writes it into the ANN buffer.
// One read outstanding at a time: 2+L cycles per word; a timed-out read parks in ERR until rst.
module coef_loader #(
  parameter int DATA_W  = 16,
  parameter int WORDS   = 64,
  parameter int ADDR_W  = 12,
  parameter int BASE0   = 0,
  parameter int BASE1   = 64,
  parameter int TIMEOUT = 255,
  localparam int IW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_coef,
  input  logic              coef_select,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              coef_wr,
  output logic [IW-1:0]     coef_addr,
  output logic [DATA_W-1:0] coef_data,
  output logic              image_weights_loaded,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE, REARM, ERR} state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   data_q;
  logic [7:0]          tcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request_coef) begin
            base_q  <= coef_select ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
            idx_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // rvalid wins over the timeout on the final allowed cycle
          if (mem_rvalid) begin
            data_q  <= mem_rdata;
            state_q <= WRITE;
          end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
            state_q <= ERR;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        WRITE: begin
          if (idx_q == IW'(WORDS - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= ISSUE;
          end
        end
        DONE:    state_q <= REARM;
        // a level request left high must not start a second block
        REARM:   if (!request_coef) state_q <= IDLE;
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd               = (state_q == ISSUE);
  assign mem_addr             = mem_rd ? (base_q + ADDR_W'(idx_q)) : '0;
  assign coef_wr              = (state_q == WRITE);
  assign coef_addr            = coef_wr ? idx_q : '0;
  assign coef_data            = coef_wr ? data_q : '0;
  assign image_weights_loaded = (state_q == DONE);
  assign busy                 = (state_q == ISSUE) || (state_q == WAIT) ||
                                (state_q == WRITE) || (state_q == DONE);
  assign err                  = (state_q == ERR);

endmodule
